// File: rtl/router_pkg.sv
// Shared definitions for the buffered mesh router.
//   N_PORTS      : number of router ports (4 mesh directions + local)
//   P_*          : port index constants
//   port_idx_t   : 3-bit port index type
//   route_port() : dimension-ordered (X then Y) route for one head flit
package router_pkg;

  localparam int N_PORTS     = 5;
  // Coordinates are zero-extended to this width before comparison, so the
  // routing function serves any COORD_W up to this limit.
  localparam int COORD_MAX_W = 16;

  typedef logic [2:0] port_idx_t;

  localparam port_idx_t P_XP    = 3'd0;
  localparam port_idx_t P_XN    = 3'd1;
  localparam port_idx_t P_YP    = 3'd2;
  localparam port_idx_t P_YN    = 3'd3;
  localparam port_idx_t P_LOCAL = 3'd4;

  function automatic port_idx_t route_port(
    input logic [COORD_MAX_W-1:0] dest_x,
    input logic [COORD_MAX_W-1:0] dest_y,
    input logic [COORD_MAX_W-1:0] self_x,
    input logic [COORD_MAX_W-1:0] self_y
  );
    port_idx_t port;
    if (dest_x > self_x)      port = P_XP;
    else if (dest_x < self_x) port = P_XN;
    else if (dest_y > self_y) port = P_YP;
    else if (dest_y < self_y) port = P_YN;
    else                      port = P_LOCAL;
    return port;
  endfunction

endpackage

// File: rtl/mesh_router_buffered_if.sv
// Flit bus of the five-port mesh router.
//   in_data/in_valid/in_ready    : one valid/ready input channel per port
//   out_data/out_valid/out_ready : one valid/ready output channel per port
// Port p occupies bits [p*STREAM_WIDTH +: STREAM_WIDTH] of the data vectors.
//   master : traffic source/sink side (neighbours, test environment)
//   slave  : router side
interface mesh_router_buffered_if #(
  parameter int STREAM_WIDTH = 144
);
  import router_pkg::*;

  logic [N_PORTS*STREAM_WIDTH-1:0] in_data;
  logic [N_PORTS-1:0]              in_valid;
  logic [N_PORTS-1:0]              in_ready;
  logic [N_PORTS*STREAM_WIDTH-1:0] out_data;
  logic [N_PORTS-1:0]              out_valid;
  logic [N_PORTS-1:0]              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/router_fifo.sv
// Per-input flit FIFO with a combinational head.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : write data_i (caller guarantees !full_o)
//   data_i     : flit to write
//   pop_i      : discard the head (caller guarantees !empty_o)
//   head_o     : oldest stored flit
//   full_o     : no free entry
//   empty_o    : no stored flit
module router_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mesh_router_buffered.sv
// Buffered five-port 2-D mesh router node.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : flit bus (slave side), ports 0=+x 1=-x 2=+y 3=-y 4=local
//   err_cnt    : saturating count of heads dropped because they route back
//                out of the port they arrived on
// Each input feeds a FIFO; each FIFO head is routed X-then-Y, and each output
// owns a round-robin arbiter plus a registered output stage.
module mesh_router_buffered
  import router_pkg::*;
#(
  parameter int STREAM_WIDTH = 144,
  parameter int COORD_W      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int SELF_X       = 0,
  parameter int SELF_Y       = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mesh_router_buffered_if.slave bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [N_PORTS-1:0]      fifo_push;
  logic [N_PORTS-1:0]      fifo_pop;
  logic [N_PORTS-1:0]      fifo_full;
  logic [N_PORTS-1:0]      fifo_empty;
  logic [STREAM_WIDTH-1:0] head     [N_PORTS];
  port_idx_t               req_port [N_PORTS];
  logic [N_PORTS-1:0]      drop;
  logic [N_PORTS-1:0]      grant    [N_PORTS];  // grant[o][p]: input p wins output o

  // in_ready is forced low during reset so no flit is taken while flushing.
  assign bus.in_ready = {N_PORTS{rst_n}} & ~fifo_full;
  assign fifo_push    = bus.in_valid & bus.in_ready;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_in
    router_fifo #(
      .WIDTH (STREAM_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push[p]),
      .data_i  (bus.in_data[p*STREAM_WIDTH +: STREAM_WIDTH]),
      .pop_i   (fifo_pop[p]),
      .head_o  (head[p]),
      .full_o  (fifo_full[p]),
      .empty_o (fifo_empty[p])
    );
  end

  // Route every head; a mesh input whose head would leave through the same
  // port is a U-turn and is discarded instead of requesting an output.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      req_port[p] = route_port(
        COORD_MAX_W'(head[p][STREAM_WIDTH-1 -: COORD_W]),
        COORD_MAX_W'(head[p][STREAM_WIDTH-1-COORD_W -: COORD_W]),
        COORD_MAX_W'(SELF_X),
        COORD_MAX_W'(SELF_Y));
      drop[p] = ~fifo_empty[p] & (p < int'(P_LOCAL)) &
                (req_port[p] == port_idx_t'(p));
    end
  end

  // Each head requests exactly one output, so at most one grant hits an input.
  always_comb begin
    fifo_pop = drop;
    for (int o = 0; o < N_PORTS; o++) fifo_pop = fifo_pop | grant[o];
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic [N_PORTS-1:0]      cand;
    logic [N_PORTS-1:0]      grant_vec;
    logic                    out_free;
    logic                    any_cand;
    port_idx_t               winner;
    port_idx_t               scan_idx;
    port_idx_t               ptr_q, ptr_d;
    logic                    valid_q, valid_d;
    logic [STREAM_WIDTH-1:0] data_q, data_d;

    always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
        cand[p] = ~fifo_empty[p] & ~drop[p] & (req_port[p] == port_idx_t'(o));
      end
    end

    assign any_cand = |cand;
    assign out_free = ~valid_q | bus.out_ready[o];

    // Scan from the far end back towards ptr_q so the last hit is the first
    // candidate at or after the pointer.
    always_comb begin
      winner   = ptr_q;
      scan_idx = ptr_q;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        scan_idx = port_idx_t'((int'(ptr_q) + k) % N_PORTS);
        if (cand[scan_idx]) winner = scan_idx;
      end
    end

    always_comb begin
      grant_vec = '0;
      if (out_free && any_cand) grant_vec[winner] = 1'b1;
    end

    assign grant[o] = grant_vec;

    always_comb begin
      ptr_d   = ptr_q;
      valid_d = valid_q;
      data_d  = data_q;
      if (out_free) begin
        valid_d = any_cand;
        if (any_cand) begin
          data_d = head[winner];
          ptr_d  = (winner == P_LOCAL) ? P_XP : winner + 3'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ptr_q   <= P_XP;
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        ptr_q   <= ptr_d;
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign bus.out_valid[o]                                = valid_q;
    assign bus.out_data[o*STREAM_WIDTH +: STREAM_WIDTH]    = data_q;
  end

  // Up to four U-turns can be dropped in one cycle; all of them are counted.
  logic [2:0]           n_drop;
  logic [ERR_CNT_W+2:0] err_sum;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    n_drop = '0;
    for (int p = 0; p < N_PORTS; p++) n_drop = n_drop + {2'b00, drop[p]};
    err_sum   = {3'b000, err_cnt_q} + {{ERR_CNT_W{1'b0}}, n_drop};
    err_cnt_d = (err_sum[ERR_CNT_W+2:ERR_CNT_W] != 3'b000) ? '1
                                                           : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mesh_router_buffered.sv
// Bench for mesh_router_buffered: directed cases followed by random traffic
// checked against a per-(input,output) ordered scoreboard.
module tb_mesh_router_buffered;

  localparam int W   = 32;
  localparam int NP  = 5;
  localparam int ECW = 2;
  localparam int SX  = 1;
  localparam int SY  = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [ECW-1:0] err_cnt;

  always #5 clk = ~clk;

  mesh_router_buffered_if #(.STREAM_WIDTH(W)) bus ();

  mesh_router_buffered #(
    .STREAM_WIDTH (W),
    .COORD_W      (2),
    .FIFO_DEPTH   (4),
    .SELF_X       (SX),
    .SELF_Y       (SY),
    .ERR_CNT_W    (ECW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: one ordered queue per (source port, output port) pair.
  logic [W-1:0] sb_q [NP*NP][$];
  int           seq [NP];
  int           exp_drops = 0;

  int d_port [5] = '{0, 1, 2, 3, 0};
  int d_dx   [5] = '{3, 0, 1, 1, 3};
  int d_dy   [5] = '{1, 1, 3, 0, 1};
  int d_err  [5] = '{1, 2, 3, 3, 3};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Flit layout: [31:30] dest_x, [29:28] dest_y, [18:3] sequence, [2:0] source.
  function automatic logic [W-1:0] mk_flit(input int src, input int sq, input int dx, input int dy);
    logic [W-1:0] f;
    f        = '0;
    f[31:30] = dx[1:0];
    f[29:28] = dy[1:0];
    f[27:19] = 9'($urandom);
    f[18:3]  = sq[15:0];
    f[2:0]   = src[2:0];
    return f;
  endfunction

  function automatic int ref_route(input logic [W-1:0] f);
    int dx, dy;
    dx = int'(f[31:30]);
    dy = int'(f[29:28]);
    if (dx > SX) return 0;
    if (dx < SX) return 1;
    if (dy > SY) return 2;
    if (dy < SY) return 3;
    return 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called on the falling edge: records what the coming rising edge transfers.
  task automatic observe();
    logic [W-1:0] d, e;
    int r, s, key;
    for (int p = 0; p < NP; p++) begin
      if (bus.in_valid[p] && bus.in_ready[p]) begin
        d = bus.in_data[p*W +: W];
        r = ref_route(d);
        if (p < 4 && r == p) exp_drops++;
        else sb_q[p*NP + r].push_back(d);
        seq[p]++;
      end
    end
    for (int o = 0; o < NP; o++) begin
      if (bus.out_valid[o] && bus.out_ready[o]) begin
        d = bus.out_data[o*W +: W];
        s = int'(d[2:0]);
        check_eq("sb_route", 64'(ref_route(d)), 64'(o));
        key = (s < NP) ? s*NP + o : 0;
        e   = '1;
        if (s < NP && sb_q[key].size() > 0) e = sb_q[key].pop_front();
        check_eq("sb_order", 64'(d), 64'(e));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [W-1:0]  f;
    logic [W-1:0]  fb [NP];
    logic [W-1:0]  fc [6];
    logic [NP-1:0] seen;
    logic          acc, push6;
    int            got, dlv, p;

    for (int i = 0; i < NP; i++) seq[i] = 0;
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_in_ready",  64'(bus.in_ready), 64'(0));
    check_eq("rst_err_cnt",   64'(err_cnt), 64'(0));
    check_eq("rst_out_data",  64'(|bus.out_data), 64'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 64'(bus.in_ready), 64'h1f);

    // Local delivery, two-cycle latency
    f = mk_flit(0, 0, 1, 1);
    bus.in_data[0 +: W] = f;
    bus.in_valid[0]     = 1'b1;
    tick();
    bus.in_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("a_early_valid", 64'(bus.out_valid), 64'(0));
    tick();
    @(negedge clk);
    check_eq("a_valid", 64'(bus.out_valid), 64'h10);
    check_eq("a_data",  64'(bus.out_data[4*W +: W]), 64'(f));
    tick();
    tick();

    // Four inputs contending for +x, served round-robin
    for (int i = 1; i < NP; i++) begin
      fb[i] = mk_flit(i, 1, 3, 1);
      bus.in_data[i*W +: W] = fb[i];
      bus.in_valid[i] = 1'b1;
    end
    tick();
    bus.in_valid = '0;
    for (int i = 1; i < NP; i++) begin
      tick();
      @(negedge clk);
      check_eq("b_valid", 64'(bus.out_valid), 64'h01);
      check_eq("b_data",  64'(bus.out_data[0 +: W]), 64'(fb[i]));
    end
    tick();
    @(negedge clk);
    check_eq("b_idle", 64'(bus.out_valid), 64'(0));

    // Pointer wrapped to 0: port 1 beats port 4
    fb[1] = mk_flit(1, 2, 3, 1);
    fb[4] = mk_flit(4, 2, 3, 1);
    bus.in_data[1*W +: W] = fb[1];
    bus.in_data[4*W +: W] = fb[4];
    bus.in_valid = 5'b10010;
    tick();
    bus.in_valid = '0;
    tick();
    @(negedge clk);
    check_eq("b2_first", 64'(bus.out_data[0 +: W]), 64'(fb[1]));
    tick();
    @(negedge clk);
    check_eq("b2_second", 64'(bus.out_data[0 +: W]), 64'(fb[4]));
    tick();
    tick();

    // Backpressure on +y: FIFO plus output register fill, then drain in order
    bus.out_ready = 5'b11011;
    for (int k = 0; k < 6; k++) fc[k] = mk_flit(4, 10 + k, 1, 2);
    got = 0;
    for (int c = 0; c < 12 && got < 6; c++) begin
      bus.in_data[4*W +: W] = fc[got];
      bus.in_valid[4] = 1'b1;
      @(negedge clk);
      acc = bus.in_ready[4];
      tick();
      if (acc) got++;
    end
    bus.in_valid[4] = 1'b0;
    @(negedge clk);
    check_eq("c_accepted",     64'(got), 64'(5));
    check_eq("c_in_ready_low", 64'(bus.in_ready[4]), 64'(0));
    check_eq("c_hold_valid",   64'(bus.out_valid[2]), 64'(1));
    check_eq("c_hold_data",    64'(bus.out_data[2*W +: W]), 64'(fc[0]));
    tick();
    tick();
    @(negedge clk);
    check_eq("c_hold_data2", 64'(bus.out_data[2*W +: W]), 64'(fc[0]));
    tick();
    bus.out_ready = '1;
    bus.in_data[4*W +: W] = fc[5];
    bus.in_valid[4] = 1'b1;
    dlv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid[2]) begin
        if (dlv < 6) check_eq("c_order", 64'(bus.out_data[2*W +: W]), 64'(fc[dlv]));
        dlv++;
      end
      push6 = bus.in_valid[4] & bus.in_ready[4];
      tick();
      if (push6) bus.in_valid[4] = 1'b0;
    end
    bus.in_valid[4] = 1'b0;
    check_eq("c_delivered", 64'(dlv), 64'(6));

    // U-turn drops and err_cnt saturation (2-bit counter)
    for (int i = 0; i < 5; i++) begin
      p = d_port[i];
      bus.in_data[p*W +: W] = mk_flit(p, 20 + i, d_dx[i], d_dy[i]);
      bus.in_valid[p] = 1'b1;
      tick();
      bus.in_valid[p] = 1'b0;
      tick();
      @(negedge clk);
      check_eq("d_err_cnt",   64'(err_cnt), 64'(d_err[i]));
      check_eq("d_no_output", 64'(bus.out_valid), 64'(0));
    end

    // Reset while flits are buffered
    bus.out_ready = 5'b11011;
    for (int k = 0; k < 3; k++) begin
      bus.in_data[4*W +: W] = mk_flit(4, 30 + k, 1, 2);
      bus.in_valid[4] = 1'b1;
      tick();
    end
    bus.in_valid[4] = 1'b0;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("e_in_ready_rst", 64'(bus.in_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("e_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("e_err_cnt",   64'(err_cnt), 64'(0));
    check_eq("e_in_ready",  64'(bus.in_ready), 64'h1f);
    bus.out_ready = '1;
    seen = '0;
    repeat (6) begin
      tick();
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check_eq("e_no_stale", 64'(seen), 64'(0));
    tick();

    // Random traffic with random backpressure
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NP; i++) begin
        bus.in_valid[i] = ($urandom_range(0, 2) != 0);
        bus.in_data[i*W +: W] = mk_flit(i, seq[i], $urandom_range(0, 3), $urandom_range(0, 3));
      end
      bus.out_ready = 5'($urandom);
      @(negedge clk);
      observe();
      tick();
    end
    bus.in_valid  = '0;
    bus.out_ready = '1;
    repeat (60) begin
      @(negedge clk);
      observe();
      tick();
    end
    for (int i = 0; i < NP*NP; i++) check_eq("sb_leftover", 64'(sb_q[i].size()), 64'(0));
    check_eq("sb_err_cnt", 64'(err_cnt), 64'((exp_drops > 3) ? 3 : exp_drops));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
